// File: rtl/anode_scan_ctrl.sv
// Multiplexed seven-segment anode scanner.
// A prescaler divides clk into slots. Each digit owns a group of slots, and
// exactly one slot in each group lights that digit's anode; the other slots
// are blanking dead-time. Digits are scanned from NUM_DIGITS-1 down to 0.
// All outputs are registered and decoded from the next-state counter values,
// so each output describes the state held after the same edge.
module anode_scan_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int PRESCALE        = 16,
    parameter int SLOTS_PER_DIGIT = 4,
    parameter int ACTIVE_SLOT     = 1,
    parameter int ACTIVE_LOW      = 1,
    localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  blank_all,
    input  logic [NUM_DIGITS-1:0] digit_mask,
    output logic [NUM_DIGITS-1:0] AN_EN,
    output logic [DW-1:0]         DIGIT_SEL,
    output logic                  frame_start
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int SW = (SLOTS_PER_DIGIT > 1) ? $clog2(SLOTS_PER_DIGIT) : 1;

    localparam logic [PW-1:0] PRE_MAX  = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SLOT_MAX = SW'(SLOTS_PER_DIGIT - 1);
    localparam logic [SW-1:0] LIT_SLOT = SW'(ACTIVE_SLOT);
    localparam logic [DW-1:0] DIG_MAX  = DW'(NUM_DIGITS - 1);

    // Level driven onto an anode that is off.
    localparam logic          OFF_LVL  = (ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{OFF_LVL}};

    logic [PW-1:0] pre_reg;
    logic [SW-1:0] slot_reg;
    logic [DW-1:0] dig_reg;

    logic [PW-1:0] pre_next;
    logic [SW-1:0] slot_next;
    logic [DW-1:0] dig_next;
    logic          wrap_next;
    logic          lit_next;
    logic [NUM_DIGITS-1:0] an_next;

    // Counter chain: prescaler -> slot -> digit; frozen while en is low.
    always_comb begin
        pre_next  = pre_reg;
        slot_next = slot_reg;
        dig_next  = dig_reg;
        wrap_next = 1'b0;
        if (en) begin
            if (pre_reg != PRE_MAX) begin
                pre_next = pre_reg + 1'b1;
            end else begin
                pre_next = '0;
                if (slot_reg != SLOT_MAX) begin
                    slot_next = slot_reg + 1'b1;
                end else begin
                    slot_next = '0;
                    if (dig_reg == '0) begin
                        dig_next  = DIG_MAX;
                        wrap_next = 1'b1;
                    end else begin
                        dig_next = dig_reg - 1'b1;
                    end
                end
            end
        end
    end

    // The lit slot is qualified by run enable and global blanking; the
    // per-digit mask and digit match are applied per anode bit below.
    assign lit_next = en && !blank_all && (slot_next == LIT_SLOT);

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_anode
            assign an_next[gi] =
                (lit_next && digit_mask[gi] && (dig_next == DW'(gi))) ^ OFF_LVL;
        end
    endgenerate

    // State and registered outputs; reset takes priority over en.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_reg     <= '0;
            slot_reg    <= '0;
            dig_reg     <= DIG_MAX;
            AN_EN       <= AN_OFF;
            DIGIT_SEL   <= DIG_MAX;
            frame_start <= 1'b0;
        end else begin
            pre_reg     <= pre_next;
            slot_reg    <= slot_next;
            dig_reg     <= dig_next;
            AN_EN       <= an_next;
            DIGIT_SEL   <= dig_next;
            frame_start <= wrap_next;
        end
    end

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Testbench for anode_scan_ctrl: a default 4-digit instance and an 8-digit
// active-high instance share run/blank/reset stimulus. A reference model
// derives the expected outputs from the count of enabled cycles since reset.
module tb_anode_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       blank_all;
    logic [3:0] mask_a;
    logic [7:0] mask_b;

    logic [3:0] an_a;
    logic [1:0] sel_a;
    logic       fs_a;
    logic [7:0] an_b;
    logic [2:0] sel_b;
    logic       fs_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: enabled cycles since reset, modulo frame length.
    int t_a = 0;
    int t_b = 0;

    always #5 clk = ~clk;

    anode_scan_ctrl dut_a (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .blank_all   (blank_all),
        .digit_mask  (mask_a),
        .AN_EN       (an_a),
        .DIGIT_SEL   (sel_a),
        .frame_start (fs_a)
    );

    anode_scan_ctrl #(
        .NUM_DIGITS      (8),
        .PRESCALE        (2),
        .SLOTS_PER_DIGIT (2),
        .ACTIVE_SLOT     (0),
        .ACTIVE_LOW      (0)
    ) dut_b (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .blank_all   (blank_all),
        .digit_mask  (mask_b),
        .AN_EN       (an_b),
        .DIGIT_SEL   (sel_b),
        .frame_start (fs_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Expected anode vector after t enabled cycles since reset.
    function automatic logic [7:0] exp_an(input int n, input int p, input int s_per,
                                          input int act, input int low, input int t,
                                          input logic run, input logic blank,
                                          input logic [7:0] mask);
        int s;
        int slot;
        int d;
        logic [7:0] v;
        s    = t / p;
        slot = s % s_per;
        d    = n - 1 - (s / s_per);
        v    = 8'h00;
        if (run && !blank && mask[d] && slot == act) v[d] = 1'b1;
        if (low != 0) v = ~v & 8'((1 << n) - 1);
        return v;
    endfunction

    function automatic int exp_sel(input int n, input int p, input int s_per, input int t);
        return n - 1 - ((t / p) / s_per);
    endfunction

    // One clock edge: advance the model with the inputs present at the edge,
    // then compare every output of both instances.
    task automatic step();
        logic       r;
        logic       e;
        logic       b;
        logic [3:0] ma;
        logic [7:0] mb;
        logic       fa;
        logic       fb;
        r  = reset;
        e  = en;
        b  = blank_all;
        ma = mask_a;
        mb = mask_b;
        fa = 1'b0;
        fb = 1'b0;
        @(posedge clk);
        if (r) begin
            t_a = 0;
            t_b = 0;
        end else if (e) begin
            t_a++;
            t_b++;
            if (t_a == 4 * 4 * 16) begin t_a = 0; fa = 1'b1; end
            if (t_b == 8 * 2 * 2)  begin t_b = 0; fb = 1'b1; end
        end
        #1;
        chk("a_an",  32'(an_a),  32'(exp_an(4, 16, 4, 1, 1, t_a, e && !r, b, {4'h0, ma})));
        chk("a_sel", 32'(sel_a), 32'(exp_sel(4, 16, 4, t_a)));
        chk("a_fs",  32'(fs_a),  32'(fa));
        chk("b_an",  32'(an_b),  32'(exp_an(8, 2, 2, 0, 0, t_b, e && !r, b, mb)));
        chk("b_sel", 32'(sel_b), 32'(exp_sel(8, 2, 2, t_b)));
        chk("b_fs",  32'(fs_b),  32'(fb));
    endtask

    initial begin
        reset     = 1'b1;
        en        = 1'b1;
        blank_all = 1'b0;
        mask_a    = 4'hF;
        mask_b    = 8'hFF;

        // Reset state.
        step();
        step();
        chk("rst_an_a",  32'(an_a),  32'h0000000F);
        chk("rst_sel_a", 32'(sel_a), 32'd3);
        chk("rst_fs_a",  32'(fs_a),  32'd0);
        chk("rst_an_b",  32'(an_b),  32'h00000000);
        chk("rst_sel_b", 32'(sel_b), 32'd7);
        $display("phase reset: checks=%0d", n_checks);

        // Two free-running frames with known timing landmarks.
        reset = 1'b0;
        for (int e = 0; e < 512; e++) begin
            step();
            case (e)
                0:   begin chk("e0_a", 32'(an_a), 32'hF); chk("e0_b", 32'(an_b), 32'h80); end
                1:   chk("e1_b", 32'(an_b), 32'h00);
                3:   chk("e3_b", 32'(an_b), 32'h40);
                14:  chk("e14_a", 32'(an_a), 32'hF);
                15:  chk("e15_a", 32'(an_a), 32'h7);
                27:  chk("e27_b", 32'(an_b), 32'h01);
                31:  begin chk("e31_fs_b", 32'(fs_b), 32'd1); chk("e31_b", 32'(an_b), 32'h80); end
                79:  chk("e79_a", 32'(an_a), 32'hB);
                143: chk("e143_a", 32'(an_a), 32'hD);
                207: chk("e207_a", 32'(an_a), 32'hE);
                255: chk("e255_fs_a", 32'(fs_a), 32'd1);
                271: chk("e271_a", 32'(an_a), 32'h7);
                511: chk("e511_fs_a", 32'(fs_a), 32'd1);
                default: ;
            endcase
        end
        $display("phase frames: checks=%0d", n_checks);

        // Randomized pauses, blanking, masking and mid-frame resets.
        for (int i = 0; i < 8000; i++) begin
            reset = ($urandom_range(0, 1499) == 0);
            en    = ($urandom_range(0, 11) != 0);
            if ($urandom_range(0, 299) == 0) blank_all = ~blank_all;
            if ($urandom_range(0, 149) == 0)
                mask_a = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
            if ($urandom_range(0, 99) == 0)
                mask_b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
            step();
        end
        $display("phase random: checks=%0d", n_checks);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
